// File: rtl/snake_body_tracker.sv
// Snake body store: holds up to MAX_LEN segment origins and advances the head one SEG_DIM
// step per accepted request. After each move, a sequential scan checks the head against
// every body segment. Segments are read back through a registered read port.
// Optional feature macro: SNAKE_WRAP_EN. When it is defined, the head wraps at the screen
// edges instead of hitting a wall.
module snake_body_tracker #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned SEG_DIM  = 10,
    parameter int unsigned XSCREEN  = 160,
    parameter int unsigned YSCREEN  = 120,
    parameter logic [7:0]  X0       = 8'd80,
    parameter logic [6:0]  Y0       = 7'd60,
    localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          init_i,
    input  logic [1:0]    dir_i,
    input  logic          grow_i,
    input  logic          step_req_i,
    output logic          busy_o,
    output logic          step_done_o,
    output logic          dead_o,
    output logic [LW-1:0] length_o,
    output logic [7:0]    head_x_o,
    output logic [6:0]    head_y_o,
    input  logic [LW-1:0] rd_idx_i,
    output logic [7:0]    rd_x_o,
    output logic [6:0]    rd_y_o,
    output logic          rd_valid_o
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [LW-1:0]       MaxLenL  = LW'(MAX_LEN);
    localparam logic [LW-1:0]       InitLenL = LW'(INIT_LEN);
    localparam logic signed [8:0]   StepX    = 9'(SEG_DIM);
    localparam logic signed [7:0]   StepY    = 8'(SEG_DIM);
    localparam logic signed [8:0]   XMax     = 9'(XSCREEN - SEG_DIM);
    localparam logic signed [7:0]   YMax     = 8'(YSCREEN - SEG_DIM);

    typedef enum logic [1:0] {StIdle, StShift, StScan, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      seg_x_q [MAX_LEN];
    logic [7:0]      seg_x_d [MAX_LEN];
    logic [6:0]      seg_y_q [MAX_LEN];
    logic [6:0]      seg_y_d [MAX_LEN];
    logic [LW-1:0]   length_q, length_d;
    logic [LW-1:0]   scan_k_q, scan_k_d;
    logic [1:0]      cur_dir_q, cur_dir_d;
    logic            dead_q, dead_d;
    logic            grow_q, grow_d;
    logic            wall_q, wall_d;
    logic [7:0]      nx_q, nx_d;
    logic [6:0]      ny_q, ny_d;
    logic [7:0]      rd_x_q, rd_x_d;
    logic [6:0]      rd_y_q, rd_y_d;
    logic            rd_valid_q, rd_valid_d;

    logic [1:0]        eff_dir;
    logic signed [8:0] hx_s, nx_s, nx_sel;
    logic signed [7:0] hy_s, ny_s, ny_sel;
    logic              wall_hit;

    function automatic logic [7:0] init_x(int unsigned i);
        return (i < INIT_LEN) ? X0 : 8'd0;
    endfunction

    function automatic logic [6:0] init_y(int unsigned i);
        return (i < INIT_LEN) ? Y0 + 7'(i * SEG_DIM) : 7'd0;
    endfunction

    // Candidate next head position from the current head and the effective direction.
    always_comb begin
        // A request for the exact opposite direction would fold the head into the neck.
        eff_dir = (dir_i == ~cur_dir_q) ? cur_dir_q : dir_i;
        hx_s    = signed'({1'b0, seg_x_q[0]});
        hy_s    = signed'({1'b0, seg_y_q[0]});
        nx_s    = hx_s;
        ny_s    = hy_s;
        unique case (eff_dir)
            2'b00: nx_s = hx_s + StepX;
            2'b01: ny_s = hy_s + StepY;
            2'b10: ny_s = hy_s - StepY;
            2'b11: nx_s = hx_s - StepX;
        endcase
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
        nx_sel   = nx_s;
        ny_sel   = ny_s;
        if (nx_s < 0)         nx_sel = XMax;
        else if (nx_s > XMax) nx_sel = '0;
        if (ny_s < 0)         ny_sel = YMax;
        else if (ny_s > YMax) ny_sel = '0;
`else
        wall_hit = (nx_s < 0) || (nx_s > XMax) || (ny_s < 0) || (ny_s > YMax);
        nx_sel   = nx_s;
        ny_sel   = ny_s;
`endif
    end

    // Step FSM, segment shift, collision scan and read-port next state; init overrides all.
    always_comb begin
        state_d    = state_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        length_d   = length_q;
        scan_k_d   = scan_k_q;
        cur_dir_d  = cur_dir_q;
        dead_d     = dead_q;
        grow_d     = grow_q;
        wall_d     = wall_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        rd_valid_d = (rd_idx_i < length_q);
        rd_x_d     = (rd_idx_i < MaxLenL) ? seg_x_q[rd_idx_i[IW-1:0]] : 8'd0;
        rd_y_d     = (rd_idx_i < MaxLenL) ? seg_y_q[rd_idx_i[IW-1:0]] : 7'd0;

        unique case (state_q)
            StIdle: begin
                if (step_req_i && !dead_q) begin
                    state_d   = StShift;
                    grow_d    = grow_i;
                    cur_dir_d = eff_dir;
                    wall_d    = wall_hit;
                    nx_d      = nx_sel[7:0];
                    ny_d      = ny_sel[6:0];
                end
            end
            StShift: begin
                if (wall_q) begin
                    dead_d = 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = nx_q;
                    seg_y_d[0] = ny_q;
                    // Growth without a move would expose a stale tail slot, so it is tied
                    // to the shift.
                    if (grow_q && (length_q < MaxLenL)) length_d = length_q + 1'b1;
                end
                scan_k_d = LW'(1);
                state_d  = StScan;
            end
            StScan: begin
                if ((seg_x_q[0] == seg_x_q[scan_k_q[IW-1:0]]) &&
                    (seg_y_q[0] == seg_y_q[scan_k_q[IW-1:0]])) begin
                    dead_d = 1'b1;
                end
                if (scan_k_q == length_q - 1'b1) state_d = StDone;
                else                             scan_k_d = scan_k_q + 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        if (init_i) begin
            state_d    = StIdle;
            length_d   = InitLenL;
            scan_k_d   = '0;
            cur_dir_d  = 2'b10;
            dead_d     = 1'b0;
            grow_d     = 1'b0;
            wall_d     = 1'b0;
            nx_d       = '0;
            ny_d       = '0;
            rd_valid_d = 1'b0;
            rd_x_d     = '0;
            rd_y_d     = '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = init_y(i);
            end
        end
    end

    // State registers with asynchronous reset to the initial snake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            length_q   <= InitLenL;
            scan_k_q   <= '0;
            cur_dir_q  <= 2'b10;
            dead_q     <= 1'b0;
            grow_q     <= 1'b0;
            wall_q     <= 1'b0;
            nx_q       <= '0;
            ny_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            scan_k_q   <= scan_k_d;
            cur_dir_q  <= cur_dir_d;
            dead_q     <= dead_d;
            grow_q     <= grow_d;
            wall_q     <= wall_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            rd_valid_q <= rd_valid_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign step_done_o = (state_q == StDone);
    assign dead_o      = dead_q;
    assign length_o    = length_q;
    assign head_x_o    = seg_x_q[0];
    assign head_y_o    = seg_y_q[0];
    assign rd_x_o      = rd_x_q;
    assign rd_y_o      = rd_y_q;
    assign rd_valid_o  = rd_valid_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker with default parameters.
module tb_snake_body_tracker;

    logic       clk;
    logic       rst_n;
    logic       init;
    logic [1:0] dir;
    logic       grow;
    logic       step_req;
    logic [4:0] rd_idx;
    logic       busy;
    logic       step_done;
    logic       dead;
    logic [4:0] length;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_valid;

    int n_vec = 0;
    int n_err = 0;

    snake_body_tracker dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_i      (init),
        .dir_i       (dir),
        .grow_i      (grow),
        .step_req_i  (step_req),
        .busy_o      (busy),
        .step_done_o (step_done),
        .dead_o      (dead),
        .length_o    (length),
        .head_x_o    (head_x),
        .head_y_o    (head_y),
        .rd_idx_i    (rd_idx),
        .rd_x_o      (rd_x),
        .rd_y_o      (rd_y),
        .rd_valid_o  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_seg(input int idx, input int ex, input int ey, input int ev,
                          input string tag);
        rd_idx = 5'(idx);
        tick();
        check({tag, "_x"}, int'(rd_x), ex);
        check({tag, "_y"}, int'(rd_y), ey);
        check({tag, "_v"}, int'(rd_valid), ev);
    endtask

    // One step request; waits (bounded) for step_done and returns its latency from accept.
    task automatic do_step(input logic [1:0] d, input logic g, input string tag,
                           output int lat);
        int seen;
        seen = 0;
        lat  = 0;
        dir = d;
        grow = g;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        grow = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (step_done) begin
                seen = 1;
                lat  = c;
                break;
            end
            tick();
        end
        check({tag, "_done"}, seen, 1);
        tick();
    endtask

    initial begin
        int lat;
        int extra_done;
        rst_n = 1'b0;
        init = 1'b0;
        dir = 2'b00;
        grow = 1'b0;
        step_req = 1'b0;
        rd_idx = '0;
        #12;
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_head_x", int'(head_x), 80);
        check("rst_head_y", int'(head_y), 60);
        check("rst_length", int'(length), 4);
        check("rst_dead", int'(dead), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        rd_seg(3, 80, 90, 1, "rst_seg3");
        rd_seg(0, 80, 60, 1, "rst_seg0");
        rd_seg(4, 0, 0, 0, "rst_seg4");

        // Single step right: latency and busy window
        dir = 2'b00;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("t2_busy", int'(busy), 1);
            check("t2_early_done", int'(step_done), 0);
            tick();
        end
        check("t2_done_c5", int'(step_done), 1);
        tick();
        check("t2_done_clr", int'(step_done), 0);
        check("t2_busy_clr", int'(busy), 0);
        check("t2_head_x", int'(head_x), 90);
        check("t2_head_y", int'(head_y), 60);
        rd_seg(1, 80, 60, 1, "t2_seg1");
        rd_seg(3, 80, 80, 1, "t2_seg3");
        check("t2_length", int'(length), 4);

        // Reverse request ignored, then step_req during busy ignored
        do_step(2'b11, 1'b0, "t4_rev", lat);
        check("t4_rev_x", int'(head_x), 100);
        check("t4_rev_y", int'(head_y), 60);
        dir = 2'b00;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        tick();
        step_req = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t4_busy_x", int'(head_x), 110);
        check("t4_busy_idle", int'(busy), 0);

        // Walk to the right wall
        for (int i = 0; i < 4; i++) do_step(2'b00, 1'b0, "t5_walk", lat);
        check("t5_at_edge", int'(head_x), 150);
        do_step(2'b00, 1'b0, "t5_wall", lat);
        check("t5_wall_lat", lat, 5);
`ifdef SNAKE_WRAP_EN
        check("t5_wrap_x", int'(head_x), 0);
        check("t5_wrap_y", int'(head_y), 60);
        check("t5_wrap_dead", int'(dead), 0);
`else
        check("t5_dead", int'(dead), 1);
        check("t5_head_x", int'(head_x), 150);
        check("t5_head_y", int'(head_y), 60);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("t5_ignored_busy", int'(busy), 0);
        check("t5_ignored_x", int'(head_x), 150);
`endif

        // init reload
        init = 1'b1;
        tick();
        init = 1'b0;
        check("init_dead", int'(dead), 0);
        check("init_head_x", int'(head_x), 80);
        check("init_head_y", int'(head_y), 60);
        check("init_length", int'(length), 4);

        // Grow to the cap along an L-shaped path
        do_step(2'b00, 1'b1, "t3_g1", lat);
        check("t3_len5", int'(length), 5);
        rd_seg(4, 80, 90, 1, "t3_seg4");
        for (int i = 0; i < 6; i++) do_step(2'b00, 1'b1, "t3_right", lat);
        for (int i = 0; i < 5; i++) do_step(2'b10, 1'b1, "t3_up", lat);
        check("t3_len16", int'(length), 16);
        do_step(2'b10, 1'b1, "t3_cap", lat);
        check("t3_cap_len", int'(length), 16);
        check("t3_cap_lat", lat, 17);
        check("t3_head_x", int'(head_x), 150);
        check("t3_head_y", int'(head_y), 0);
        check("t3_dead", int'(dead), 0);
        rd_seg(15, 80, 80, 1, "t3_seg15");
        rd_seg(16, 0, 0, 0, "t3_seg16");

        // Self collision
        init = 1'b1;
        tick();
        init = 1'b0;
        do_step(2'b00, 1'b1, "t6_right", lat);
        do_step(2'b01, 1'b0, "t6_down", lat);
        check("t6_alive", int'(dead), 0);
        do_step(2'b11, 1'b0, "t6_left", lat);
        check("t6_dead", int'(dead), 1);
        check("t6_head_x", int'(head_x), 80);
        check("t6_head_y", int'(head_y), 70);
        rd_seg(4, 80, 70, 1, "t6_seg4");
        init = 1'b1;
        tick();
        init = 1'b0;
        check("t6_init_dead", int'(dead), 0);
        check("t6_init_len", int'(length), 4);
        rd_seg(3, 80, 90, 1, "t6_init_seg3");

        // init mid-SCAN aborts the step without step_done
        dir = 2'b00;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        tick();
        check("abort_in_scan", int'(busy), 1);
        init = 1'b1;
        tick();
        init = 1'b0;
        check("abort_busy", int'(busy), 0);
        extra_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (step_done) extra_done++;
            tick();
        end
        check("abort_no_done", extra_done, 0);
        check("abort_head_x", int'(head_x), 80);
        check("abort_head_y", int'(head_y), 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
